// File: rtl/sound_mixer_pkg.sv
// Shared definitions for the sound_mixer_mc stereo mixer: register map,
// frame state encoding and volume helpers.
package sound_mixer_pkg;

   localparam logic [7:0] REG_RESET    = 8'h00;
   localparam logic [7:0] REG_VOL_BASE = 8'h10;
   localparam logic [7:0] REG_MASTER_L = 8'h30;
   localparam logic [7:0] REG_MASTER_R = 8'h31;
   localparam logic [7:0] REG_MUTE     = 8'h40;
   localparam logic [7:0] REG_STATUS   = 8'h41;

   localparam logic [4:0] VOL_DEFAULT  = 5'h1F;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      MASTER,
      SAT
   } state_t;

   // Full-scale volume 0x1F maps to no shift; each step down in v[4:1] adds one shift.
   function automatic logic [3:0] vol_shift(input logic [4:0] v);
      return ~v[4:1];
   endfunction

   function automatic logic [4:0] vol_step(input logic [4:0] cur, input logic [4:0] tgt);
      if (cur < tgt) begin
         return cur + 5'd1;
      end else if (cur > tgt) begin
         return cur - 5'd1;
      end
      return cur;
   endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// Indexed 8-bit register port of the mixer (mixer-index / mixer-data pair from the parent).
interface sound_mixer_if;

   logic [7:0] reg_addr;
   logic       reg_we;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   modport master (
      output reg_addr,
      output reg_we,
      output reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_we,
      input  reg_wdata,
      output reg_rdata
   );

endinterface

// File: rtl/sound_mixer_sat.sv
// Combinational clamp of a wide signed accumulator onto the signed WIDTH-bit output range.
module sound_mixer_sat #(
   parameter int ACC_W = 19,
   parameter int WIDTH = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [WIDTH-1:0] sat
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   always_comb begin
      sat = acc[WIDTH-1:0];
      if (acc > ACC_MAX) begin
         sat = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (acc < ACC_MIN) begin
         sat = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

endmodule

// File: rtl/sound_mixer_mc.sv
// Parametrised N-channel stereo mixer, one channel accumulated per clock after sample_ce.
// Optional macro SOUND_MIXER_SOFT_RAMP_EN: effective volumes ramp one step per output sample.
module sound_mixer_mc
   import sound_mixer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_ce,
   input  logic [CHANNELS*WIDTH-1:0] in_l,
   input  logic [CHANNELS*WIDTH-1:0] in_r,
   sound_mixer_if.slave              regs,
   output logic [WIDTH-1:0]          out_l,
   output logic [WIDTH-1:0]          out_r,
   output logic                      out_valid,
   output logic                      busy
);

   localparam int ACC_W = WIDTH + $clog2(CHANNELS) + 1;
   localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);
   localparam logic [7:0] VOL_END = 8'(16 + 2 * CHANNELS);

   state_t state, state_next;

   logic [4:0] vol_l [CHANNELS];
   logic [4:0] vol_r [CHANNELS];
   logic [4:0] master_l, master_r;
   logic [CHANNELS-1:0] mute;
   logic overrun;

   logic [4:0] eff_l [CHANNELS];
   logic [4:0] eff_r [CHANNELS];
   logic [4:0] eff_master_l, eff_master_r;
   logic ramp;

   logic [CHANNELS*WIDTH-1:0] snap_l, snap_r;
   logic [4:0] sh_vol_l [CHANNELS];
   logic [4:0] sh_vol_r [CHANNELS];
   logic [4:0] sh_master_l, sh_master_r;
   logic [CHANNELS-1:0] sh_mute;

   logic [CNT_W-1:0] chan;
   logic signed [ACC_W-1:0] acc_l, acc_r;
   logic signed [ACC_W-1:0] contrib_l, contrib_r;
   logic signed [ACC_W-1:0] mst_l, mst_r;
   logic signed [WIDTH-1:0] sat_l, sat_r;
   logic [WIDTH-1:0] samp_l, samp_r;

   logic vol_hit, reg_reset_wr;
   logic [4:0] vol_off;
   logic [3:0] vol_idx;
   logic [7:0] rd_next;

   function automatic logic signed [ACC_W-1:0] attenuate(input logic signed [ACC_W-1:0] x,
                                                         input logic [4:0] v);
      if (v == 5'd0) begin
         return '0;
      end
      return x >>> vol_shift(v);
   endfunction

   assign vol_off      = 5'(regs.reg_addr - REG_VOL_BASE);
   assign vol_idx      = vol_off[4:1];
   assign vol_hit      = (regs.reg_addr >= REG_VOL_BASE) && (regs.reg_addr < VOL_END);
   assign reg_reset_wr = regs.reg_we && (regs.reg_addr == REG_RESET);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (sample_ce) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (chan == LAST_CH) begin
               state_next = MASTER;
            end
         end
         MASTER: state_next = SAT;
         SAT: begin
            out_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Live register file; a frame in flight only ever sees its shadow copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            vol_l[i] <= VOL_DEFAULT;
            vol_r[i] <= VOL_DEFAULT;
         end
         master_l <= VOL_DEFAULT;
         master_r <= VOL_DEFAULT;
         mute     <= '0;
         overrun  <= 1'b0;
      end else begin
         if (reg_reset_wr) begin
            for (int i = 0; i < CHANNELS; i++) begin
               vol_l[i] <= VOL_DEFAULT;
               vol_r[i] <= VOL_DEFAULT;
            end
            master_l <= VOL_DEFAULT;
            master_r <= VOL_DEFAULT;
            mute     <= '0;
         end else if (regs.reg_we) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (vol_hit && vol_idx == 4'(i)) begin
                  if (vol_off[0]) begin
                     vol_r[i] <= regs.reg_wdata[7:3];
                  end else begin
                     vol_l[i] <= regs.reg_wdata[7:3];
                  end
               end
            end
            if (regs.reg_addr == REG_MASTER_L) begin
               master_l <= regs.reg_wdata[7:3];
            end
            if (regs.reg_addr == REG_MASTER_R) begin
               master_r <= regs.reg_wdata[7:3];
            end
            if (regs.reg_addr == REG_MUTE) begin
               for (int i = 0; i < CHANNELS; i++) begin
                  mute[i] <= (i < 8) ? regs.reg_wdata[i[2:0]] : 1'b0;
               end
            end
         end
         if (sample_ce && busy) begin
            overrun <= 1'b1;
         end else if (regs.reg_we && regs.reg_addr == REG_STATUS) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef SOUND_MIXER_SOFT_RAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            eff_l[i] <= VOL_DEFAULT;
            eff_r[i] <= VOL_DEFAULT;
         end
         eff_master_l <= VOL_DEFAULT;
         eff_master_r <= VOL_DEFAULT;
      end else if (reg_reset_wr) begin
         for (int i = 0; i < CHANNELS; i++) begin
            eff_l[i] <= VOL_DEFAULT;
            eff_r[i] <= VOL_DEFAULT;
         end
         eff_master_l <= VOL_DEFAULT;
         eff_master_r <= VOL_DEFAULT;
      end else if (out_valid) begin
         for (int i = 0; i < CHANNELS; i++) begin
            eff_l[i] <= vol_step(eff_l[i], vol_l[i]);
            eff_r[i] <= vol_step(eff_r[i], vol_r[i]);
         end
         eff_master_l <= vol_step(eff_master_l, master_l);
         eff_master_r <= vol_step(eff_master_r, master_r);
      end
   end

   always_comb begin
      ramp = (eff_master_l != master_l) || (eff_master_r != master_r);
      for (int i = 0; i < CHANNELS; i++) begin
         if (eff_l[i] != vol_l[i] || eff_r[i] != vol_r[i]) begin
            ramp = 1'b1;
         end
      end
   end
`else
   assign eff_l        = vol_l;
   assign eff_r        = vol_r;
   assign eff_master_l = master_l;
   assign eff_master_r = master_r;
   assign ramp         = 1'b0;
`endif

   always_comb begin
      rd_next = 8'h00;
      for (int i = 0; i < CHANNELS; i++) begin
         if (vol_hit && vol_idx == 4'(i)) begin
            rd_next = {(vol_off[0] ? vol_r[i] : vol_l[i]), 3'b000};
         end
      end
      case (regs.reg_addr)
         REG_MASTER_L: rd_next = {master_l, 3'b000};
         REG_MASTER_R: rd_next = {master_r, 3'b000};
         REG_MUTE: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (i < 8) begin
                  rd_next[i[2:0]] = mute[i];
               end
            end
         end
         REG_STATUS: rd_next = {5'b00000, ramp, busy, overrun};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs.reg_rdata <= 8'h00;
      end else begin
         regs.reg_rdata <= rd_next;
      end
   end

   assign samp_l = snap_l[chan*WIDTH +: WIDTH];
   assign samp_r = snap_r[chan*WIDTH +: WIDTH];

   always_comb begin
      contrib_l = '0;
      contrib_r = '0;
      if (!sh_mute[chan]) begin
         contrib_l = attenuate({{(ACC_W-WIDTH){samp_l[WIDTH-1]}}, samp_l}, sh_vol_l[chan]);
         contrib_r = attenuate({{(ACC_W-WIDTH){samp_r[WIDTH-1]}}, samp_r}, sh_vol_r[chan]);
      end
   end

   assign mst_l = attenuate(acc_l, sh_master_l);
   assign mst_r = attenuate(acc_r, sh_master_r);

   sound_mixer_sat #(.ACC_W(ACC_W), .WIDTH(WIDTH)) u_sat_l (.acc(mst_l), .sat(sat_l));
   sound_mixer_sat #(.ACC_W(ACC_W), .WIDTH(WIDTH)) u_sat_r (.acc(mst_r), .sat(sat_r));

   // Master shift and clamp resolve on the MASTER edge so the result is on out_l/out_r
   // during the SAT cycle, coincident with out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan        <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         snap_l      <= '0;
         snap_r      <= '0;
         sh_master_l <= VOL_DEFAULT;
         sh_master_r <= VOL_DEFAULT;
         sh_mute     <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            sh_vol_l[i] <= VOL_DEFAULT;
            sh_vol_r[i] <= VOL_DEFAULT;
         end
         out_l <= '0;
         out_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sample_ce) begin
                  snap_l      <= in_l;
                  snap_r      <= in_r;
                  sh_vol_l    <= eff_l;
                  sh_vol_r    <= eff_r;
                  sh_master_l <= eff_master_l;
                  sh_master_r <= eff_master_r;
                  sh_mute     <= mute;
                  acc_l       <= '0;
                  acc_r       <= '0;
                  chan        <= '0;
               end
            end
            ACCUM: begin
               acc_l <= acc_l + contrib_l;
               acc_r <= acc_r + contrib_r;
               if (chan != LAST_CH) begin
                  chan <= chan + 1'b1;
               end
            end
            MASTER: begin
               out_l <= sat_l;
               out_r <= sat_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sound_mixer_mc.md
Name: sound_mixer_mc

Overview:
- Parametrised N-channel stereo output mixer; successor to the fixed 3-source mixer stage in the sound block.
- Sums CHANNELS signed stereo sources (DSP, OPL, CMS, future sources) using per-channel volume, per-channel mute and master volume, then saturates to WIDTH.
- Time-multiplexed: one channel accumulated per clk after each sample strobe.
- Sits between the sound sources and the board audio output. It is controlled through an 8-bit indexed register port, the mixer-index/mixer-data pair decoded by the parent.

Parameters:
- CHANNELS, 4, number of stereo sources (1..16).
- WIDTH, 16, sample width in bits, signed two's complement, for inputs and outputs.
- (localparam) ACC_W = WIDTH + $clog2(CHANNELS) + 1, accumulator width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. Single clock domain.
- sample_ce  in  1  one-cycle strobe that starts a mix frame.
- in_l  in  CHANNELS*WIDTH  packed left samples; channel n occupies bits [n*WIDTH +: WIDTH].
- in_r  in  CHANNELS*WIDTH  packed right samples, same packing.
- reg_addr  in  8  register index.
- reg_we  in  1  write strobe, one cycle.
- reg_wdata  in  8  write data.
- reg_rdata  out  8  read data, registered, valid 1 cycle after reg_addr.
- out_l  out  WIDTH  mixed left output.
- out_r  out  WIDTH  mixed right output.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Registers:
  - 0x00: any write restores all volumes to 0x1F and clears mute.
  - 0x10+2n: channel n left volume, bits [7:3].
  - 0x11+2n: channel n right volume, bits [7:3].
  - 0x30 / 0x31: master left / right volume, bits [7:3].
  - 0x40: mute mask, bit n mutes channel n. Bits >= CHANNELS read 0.
  - 0x41: status. bit0 = overrun (sticky; any write clears it). bit1 = busy.
  - Unmapped indices read 0x00 and ignore writes.
- Reset values: all volumes 0x1F, mute 0, overrun 0, state IDLE, out_l/out_r 0, out_valid 0, reg_rdata 0.
- Gain: a volume v of 0 forces a contribution of 0. Otherwise the contribution is the sample arithmetically shifted right by ~v[4:1], giving 0..15 steps.
- FSM:
  - IDLE: on sample_ce, snapshot in_l/in_r, all volumes and the mute mask into shadow registers; clear accumulators; go to ACCUM.
  - ACCUM: channel counter 0..CHANNELS-1. Each cycle add the sign-extended, attenuated channel (L and R in parallel) into the ACC_W-bit accumulators. After the last channel go to MASTER.
  - MASTER: one cycle; apply the master shift to the accumulators. Go to SAT.
  - SAT: clamp each side to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; load out_l/out_r; pulse out_valid; go to IDLE.
- Latency: sample_ce in cycle t produces out_valid in cycle t+CHANNELS+2. busy is high from t+1 through the out_valid cycle.
- sample_ce while busy is ignored and sets overrun. sample_ce in the SAT cycle counts as busy.
- Register writes during a frame update the live registers only. The frame in progress uses its shadow copies; the next frame uses the new values.
- Register write and status read in the same cycle: reg_rdata returns the pre-write value.
- Reset asserted mid-frame: asynchronous return to IDLE with all reset values. No out_valid is produced for the aborted frame.
- out_l/out_r hold their value between frames.

Optional Feature:
- Macro: SOUND_MIXER_SOFT_RAMP_EN.
- With the macro defined, each channel and master side has an effective-volume register. On every out_valid, each effective volume moves one step (±1) toward its programmed value. The shadow snapshot uses the effective volumes, so there is no zipper noise. Writes to 0x00 and reset set the effective volumes immediately.
- Without the macro, programmed volumes are used directly. Status bit2 reads 0.
- With the macro, status bit2 = ramp-in-progress.

Decomposition:
- Shared package sound_mixer_pkg holds:
  - register index constants (REG_RESET, REG_VOL_BASE, REG_MASTER_L, REG_MASTER_R, REG_MUTE, REG_STATUS);
  - the state enum (IDLE, ACCUM, MASTER, SAT);
  - default volume 5'h1F.
- One natural sub-module: sound_mixer_sat, a combinational ACC_W-to-WIDTH clamp instantiated once per side.

Test Plan:
1. Defaults; ch0 L/R=0x1000, others 0; sample_ce -> out_valid 6 cycles later; out_l=out_r=0x1000.
2. All four channels L=0x7000 -> out_l=0x7FFF. All four R=0x8000 -> out_r=0x8000 (saturation both rails).
3. Write 0x10=0x78 (v=15, shift 8); ch0 L=0x4000 -> out_l=0x0040. Write 0x10=0x00 -> out_l=0x0000.
4. Write 0x40=0x02; ch1 L=0x0100, ch0 L=0x0010 -> out_l=0x0010. Read 0x40 -> 0x02.
5. Second sample_ce 2 cycles after the first -> single out_valid; 0x41 reads 0x01; write 0x41 -> reads 0x00.
6. Assert rst during ACCUM -> out_l=out_r=0, busy=0, no out_valid; 0x10 reads 0xF8.
